// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line scheduler: attribute slot
// layout, scheduler FSM states and default geometry.
package sprite_pkg;

    localparam int          H_ACTIVE_DEF   = 640;
    localparam int          SPRITE_DIM_DEF = 32;
    localparam logic [23:0] TRANSPARENT    = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_FETCH,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       enable;
        logic [9:0] x;
        logic [9:0] y;
    } attr_t;

    function automatic attr_t make_attr(input logic en, input logic [9:0] x, input logic [9:0] y);
        attr_t a;
        a.enable = en;
        a.x      = x;
        a.y      = y;
        return a;
    endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Sprite ROM fetch port and prefetch line-buffer write port.
interface sprite_line_scheduler_if #(
    parameter int IDX_W = 3
);
    // rom_req is a request/acknowledge handshake: once raised, rom_req and rom_addr
    // stay constant until the cycle rom_ack is high (rom_data is valid that same
    // cycle); the address may move only on the following cycle. wr_en is a
    // single-cycle write strobe with no backpressure.
    logic                rom_req;
    logic [IDX_W+9:0]    rom_addr;
    logic                rom_ack;
    logic [23:0]         rom_data;
    logic                wr_en;
    logic [9:0]          wr_addr;
    logic [23:0]         wr_data;

    modport master (
        output rom_req, rom_addr, wr_en, wr_addr, wr_data,
        input  rom_ack, rom_data
    );

    modport slave (
        input  rom_req, rom_addr, wr_en, wr_addr, wr_data,
        output rom_ack, rom_data
    );
endinterface

// File: rtl/sprite_hit_check.sv
// Vertical hit test for one sprite slot against a scanline, plus the sprite row.
module sprite_hit_check
    import sprite_pkg::*;
#(
    parameter int SPRITE_DIM = SPRITE_DIM_DEF
) (
    input  logic       enable,
    input  logic [9:0] y,
    input  logic [9:0] line,
    output logic       hit,
    output logic [4:0] row
);

    logic [10:0] y_top;

    // 11-bit compare so a sprite near the bottom never wraps onto the top lines.
    always_comb begin
        y_top = {1'b0, y} + 11'(SPRITE_DIM - 1);
        hit   = enable && ({1'b0, line} >= {1'b0, y}) && ({1'b0, line} <= y_top);
        row   = line[4:0] - y[4:0];
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Builds one prefetch scanline: clears the line buffer, then walks the sprite
// attribute slots from high to low index, fetching and writing opaque pixels.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter  int NUM_SPRITES = 8,
    parameter  int SPRITE_DIM  = SPRITE_DIM_DEF,
    parameter  int H_ACTIVE    = H_ACTIVE_DEF,
    localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    attr_we,
    input  logic [IDX_W-1:0]        attr_idx,
    input  logic [23:0]             attr_data,
    input  logic                    line_start,
    input  logic [9:0]              next_line,
    sprite_line_scheduler_if.master bus,
    output logic                    busy,
    output logic                    line_done,
    output logic                    overrun,
    output state_t                  dbg_state
);

    localparam logic [4:0]       LAST_COL  = 5'(SPRITE_DIM - 1);
    localparam logic [9:0]       LAST_PIX  = 10'(H_ACTIVE - 1);
    localparam logic [IDX_W-1:0] TOP_SLOT  = IDX_W'(NUM_SPRITES - 1);

    state_t             state_q,     state_d;
    logic [9:0]         line_q,      line_d;
    logic [IDX_W-1:0]   slot_q,      slot_d;
    logic [9:0]         clear_ptr_q, clear_ptr_d;
    logic [4:0]         col_q,       col_d;
    logic [4:0]         row_q,       row_d;
    logic               rom_req_q,   rom_req_d;
    logic [IDX_W+9:0]   rom_addr_q,  rom_addr_d;
    logic               wr_en_q,     wr_en_d;
    logic [9:0]         wr_addr_q,   wr_addr_d;
    logic [23:0]        wr_data_q,   wr_data_d;
    logic               busy_q,      busy_d;
    logic               line_done_q, line_done_d;
    logic               overrun_q,   overrun_d;
    attr_t              attr_q [NUM_SPRITES];
    attr_t              attr_d [NUM_SPRITES];

    attr_t              cur_attr;
    logic               hit;
    logic [4:0]         hit_row;
    logic [10:0]        x_sum;
    logic               unused_rsvd;

    assign unused_rsvd = ^attr_data[22:20];
    assign cur_attr    = attr_q[slot_q];
    assign x_sum       = {1'b0, cur_attr.x} + {6'd0, col_q};

    sprite_hit_check #(
        .SPRITE_DIM (SPRITE_DIM)
    ) u_hit_check (
        .enable (cur_attr.enable),
        .y      (cur_attr.y),
        .line   (line_q),
        .hit    (hit),
        .row    (hit_row)
    );

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        slot_d      = slot_q;
        clear_ptr_d = clear_ptr_q;
        col_d       = col_q;
        row_d       = row_q;
        rom_req_d   = rom_req_q;
        rom_addr_d  = rom_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        line_done_d = 1'b0;
        overrun_d   = overrun_q;
        attr_d      = attr_q;

        if (attr_we) begin
            attr_d[attr_idx] = make_attr(attr_data[23], attr_data[19:10], attr_data[9:0]);
        end

        // A new line request always wins: any in-flight fetch is abandoned.
        if (line_start) begin
            overrun_d   = overrun_q | (state_q != ST_IDLE);
            line_d      = next_line;
            slot_d      = TOP_SLOT;
            clear_ptr_d = '0;
            rom_req_d   = 1'b0;
            state_d     = ST_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CLEAR: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clear_ptr_q;
                    wr_data_d = TRANSPARENT;
                    if (clear_ptr_q == LAST_PIX) begin
                        state_d = ST_SCAN;
                    end else begin
                        clear_ptr_d = clear_ptr_q + 10'd1;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        col_d      = 5'd0;
                        row_d      = hit_row;
                        rom_req_d  = 1'b1;
                        rom_addr_d = {slot_q, hit_row, 5'd0};
                        state_d    = ST_FETCH;
                    end else if (slot_q == '0) begin
                        line_done_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        slot_d = slot_q - IDX_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (bus.rom_ack) begin
                        if ((bus.rom_data != TRANSPARENT) && (x_sum < 11'(H_ACTIVE))) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = x_sum[9:0];
                            wr_data_d = bus.rom_data;
                        end
                        if (col_q == LAST_COL) begin
                            rom_req_d = 1'b0;
                            if (slot_q == '0) begin
                                line_done_d = 1'b1;
                                state_d     = ST_DONE;
                            end else begin
                                slot_d  = slot_q - IDX_W'(1);
                                state_d = ST_SCAN;
                            end
                        end else begin
                            col_d      = col_q + 5'd1;
                            rom_addr_d = {slot_q, row_q, col_q + 5'd1};
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            slot_q      <= '0;
            clear_ptr_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rom_req_q   <= 1'b0;
            rom_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                attr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            slot_q      <= slot_d;
            clear_ptr_q <= clear_ptr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rom_req_q   <= rom_req_d;
            rom_addr_q  <= rom_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
            attr_q      <= attr_d;
        end
    end

    assign bus.rom_req  = rom_req_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = busy_q;
    assign line_done    = line_done_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/sprite_line_scheduler.md
SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 Parameter NUM_SPRITES, default 8, number of sprite attribute slots (power of two, 2..16).
REQ-002 Parameter SPRITE_DIM, default 32, sprite width and height in pixels.
REQ-003 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 attr_we  in  1  attribute table write strobe.
REQ-007 attr_idx  in  log2(NUM_SPRITES)  slot written.
REQ-008 attr_data  in  24  [9:0] y, [19:10] x, [22:20] reserved, [23] enable.
REQ-009 line_start  in  1  one-cycle pulse: begin building line next_line.
REQ-010 next_line  in  10  scanline to prefetch; sampled only on line_start.
REQ-011 rom_req  out  1  sprite pixel fetch request.
REQ-012 rom_addr  out  log2(NUM_SPRITES)+10  {slot, row[4:0], col[4:0]}.
REQ-013 rom_ack  in  1  fetch complete; rom_data valid in the same cycle.
REQ-014 rom_data  in  24  RGB888 pixel; 24'h000000 means transparent.
REQ-015 wr_en, wr_addr[9:0], wr_data[23:0]  out  prefetch line-buffer write port.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 line_done  out  1  one-cycle pulse when the line is complete.
REQ-018 overrun  out  1  sticky flag; line_start arrived while busy.

Function
REQ-019 FSM states: IDLE, CLEAR, SCAN, FETCH, DONE.
REQ-020 IDLE + line_start: latch next_line, set slot = NUM_SPRITES-1, clear_ptr = 0, go to CLEAR.
REQ-021 CLEAR: write wr_data=0 at wr_addr=clear_ptr each cycle for H_ACTIVE cycles (0..639), then go to SCAN.
REQ-022 SCAN, one cycle per slot: slot is a hit if enable=1 and y <= line <= y+SPRITE_DIM-1; compare at 11 bits, no wrap.
REQ-023 SCAN hit: set col=0 and row=line-y[4:0], go to FETCH; miss: slot 0 goes to DONE, otherwise decrement slot.
REQ-024 FETCH: hold rom_req=1 and rom_addr stable until rom_ack; rom_addr may change only in the cycle after the ack.
REQ-025 Write on ack when rom_data!=0 and x+col < H_ACTIVE (11-bit sum): wr_en=1, wr_addr=x+col, wr_data=rom_data, all registered one cycle after the ack.
REQ-026 Skip the write on ack when rom_data==0 or x+col >= H_ACTIVE; the fetch still occurs.
REQ-027 After ack with col=SPRITE_DIM-1: slot 0 goes to DONE, otherwise decrement slot and return to SCAN.
REQ-028 Slots are processed from high to low index, so the lower index wins at overlapping pixels.
REQ-029 DONE: pulse line_done for one cycle, then go to IDLE.
REQ-030 line_start while busy: set overrun, drop the in-flight fetch, and restart at CLEAR with the new next_line.
REQ-031 rom_ack outside FETCH is ignored.
REQ-032 attr_we takes effect the next cycle; a write during a build may be observed or not, with no error.
REQ-033 Minimum latency from line_start to line_done: 1+H_ACTIVE+NUM_SPRITES+32*hits*(1+ack_wait) cycles.

Reset
REQ-034 reset low: state=IDLE; rom_req, wr_en, busy, line_done, overrun = 0; rom_addr, wr_addr, wr_data = 0; attribute table entries cleared (enable=0).
REQ-035 reset deassertion mid-build: no partial write or line_done is emitted.

Structure
REQ-036 Shared package sprite_pkg: attribute struct (y, x, enable), the FSM state enum, and constants H_ACTIVE_DEF=640, SPRITE_DIM_DEF=32, TRANSPARENT=24'h0.
REQ-037 Sub-module sprite_hit_check: combinational hit test plus row computation, instantiated once.

Verification
REQ-038 Reset, then line_start with line=5 and no sprites enabled -> 640 zero writes, line_done 647+ cycles later, rom_req never high.
REQ-039 Slot 0 at x=100, y=0, line=10, ack immediate, data=24'h00FF00 -> 32 writes at addr 100..131, rom_addr row field=10.
REQ-040 Slot 1 and slot 2 overlap at x=200 on line 3 -> slot 2 writes first, slot 1 overwrites addr 200..231.
REQ-041 Sprite at x=620 -> 32 fetches, writes only at addr 620..639.
REQ-042 rom_ack delayed 3 cycles -> rom_req and rom_addr held stable; rom_data=0 on col 7 -> no write at x+7.
REQ-043 Second line_start mid-FETCH -> overrun=1, CLEAR restarts at addr 0 with the new line; async reset mid-build -> all outputs 0 immediately.
